// File: rtl/drone_cmd_sequencer_if.sv
// Command push channel into the drone command sequencer.
// The master drives commands, and the slave reports whether its FIFO has room.
interface drone_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_data;
  logic [63:0] cmd_target;

  modport master (
    output cmd_valid,
    output cmd_data,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  cmd_target,
    output cmd_ready
  );
endinterface

// File: rtl/drone_cmd_sequencer.sv
// Queues flight commands and applies them to the drone controller one at a time.
// After a settle time it checks each motor's RPM against its target window.
module drone_cmd_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SETTLE_CYC = 50,
  parameter int unsigned HOLD_CYC   = 24,
  parameter int unsigned WINDOW     = 6
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_abort,
  drone_cmd_sequencer_if.slave   cmd_if,
  input  logic [3:0][15:0]       i_rpm_sense,
  output logic [2:0]             o_altcmd,
  output logic [2:0]             o_dircmd0,
  output logic [2:0]             o_dircmd1,
  output logic                   o_busy,
  output logic                   o_chk_valid,
  output logic [3:0]             o_chk_fail,
  output logic [15:0]            o_fail_cnt,
  output logic [15:0]            o_seq_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYC - 1);
  localparam logic signed [17:0] WIN  = 18'(WINDOW);

  typedef enum logic [2:0] {StIdle, StFetch, StSettle, StCheck, StHold} state_e;

  state_e            r_state;
  logic [15:0]       r_cnt;
  logic [72:0]       r_mem [DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [3:0][15:0]  r_tgt;
  logic [2:0]        r_altcmd, r_dircmd0, r_dircmd1;
  logic              r_busy, r_chk_valid;
  logic [3:0]        r_chk_fail;
  logic [15:0]       r_fail_cnt, r_seq_idx;

  logic              w_full, w_empty, w_push, w_pop, w_leave;
  logic [72:0]       w_head;
  logic [3:0]        w_fail;
  logic signed [17:0] w_sense_x [4];
  logic signed [17:0] w_tgt_x   [4];

  // Extra pointer bit distinguishes full from empty.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = cmd_if.cmd_valid && !w_full && !i_abort;
  assign w_pop   = (r_state == StFetch) && !i_abort;
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign cmd_if.cmd_ready = !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_if.cmd_data, cmd_if.cmd_target};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // 18-bit sign-extended window compare so extreme targets cannot wrap into a pass.
  always_comb begin
    w_fail = '0;
    for (int i = 0; i < 4; i++) begin
      w_sense_x[i] = 18'($signed(i_rpm_sense[i]));
      w_tgt_x[i]   = 18'($signed(r_tgt[i]));
      w_fail[i]    = (w_sense_x[i] > w_tgt_x[i] + WIN) || (w_sense_x[i] < w_tgt_x[i] - WIN);
    end
  end

  assign w_leave = ((r_state == StCheck) && (HOLD_CYC == 0)) ||
                   ((r_state == StHold) && (r_cnt == HOLD_LAST));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_tgt       <= '0;
      r_altcmd    <= '0;
      r_dircmd0   <= '0;
      r_dircmd1   <= '0;
      r_busy      <= 1'b0;
      r_chk_valid <= 1'b0;
      r_chk_fail  <= '0;
      r_fail_cnt  <= '0;
      r_seq_idx   <= '0;
    end else if (i_abort) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_altcmd    <= '0;
      r_dircmd0   <= '0;
      r_dircmd1   <= '0;
      r_busy      <= 1'b0;
      r_chk_valid <= 1'b0;
      r_chk_fail  <= '0;
      r_fail_cnt  <= '0;
      r_seq_idx   <= '0;
    end else begin
      r_chk_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            r_state <= StFetch;
            r_busy  <= 1'b1;
          end
        end
        StFetch: begin
          r_altcmd  <= w_head[72:70];
          r_dircmd0 <= w_head[69:67];
          r_dircmd1 <= w_head[66:64];
          r_tgt[0]  <= w_head[63:48];
          r_tgt[1]  <= w_head[47:32];
          r_tgt[2]  <= w_head[31:16];
          r_tgt[3]  <= w_head[15:0];
          r_cnt     <= '0;
          r_state   <= StSettle;
        end
        StSettle: begin
          if (r_cnt == SETTLE_LAST) r_state <= StCheck;
          else                      r_cnt   <= r_cnt + 16'd1;
        end
        StCheck: begin
          r_chk_fail  <= w_fail;
          r_chk_valid <= 1'b1;
          if ((|w_fail) && (r_fail_cnt != 16'hFFFF)) r_fail_cnt <= r_fail_cnt + 16'd1;
          r_seq_idx   <= r_seq_idx + 16'd1;
          r_cnt       <= '0;
          r_state     <= StHold;
        end
        StHold: begin
          r_cnt <= r_cnt + 16'd1;
        end
        default: r_state <= StIdle;
      endcase
      // End of a command slot: chain to the next command or fall back to hover.
      if (w_leave) begin
        if (!w_empty) begin
          r_state <= StFetch;
        end else begin
          r_state   <= StIdle;
          r_busy    <= 1'b0;
          r_altcmd  <= '0;
          r_dircmd0 <= '0;
          r_dircmd1 <= '0;
        end
      end
    end
  end

  assign o_altcmd    = r_altcmd;
  assign o_dircmd0   = r_dircmd0;
  assign o_dircmd1   = r_dircmd1;
  assign o_busy      = r_busy;
  assign o_chk_valid = r_chk_valid;
  assign o_chk_fail  = r_chk_fail;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_seq_idx   = r_seq_idx;

endmodule

// File: tb/tb_drone_cmd_sequencer.sv
// Scoreboard bench for drone_cmd_sequencer: expected check results are queued at push
// time and popped when chk_valid pulses.
module tb_drone_cmd_sequencer;
  localparam int S = 50;
  localparam int H = 24;
  localparam int W = 6;
  localparam int D = 8;
  localparam int PERIOD = S + H + 2;

  logic clk = 1'b0;
  logic rst, abort;
  logic [3:0][15:0] rpm;
  logic [2:0] alt, d0, d1;
  logic busy, cv;
  logic [3:0] cf;
  logic [15:0] fc, si;

  drone_cmd_sequencer_if cmd_if();

  drone_cmd_sequencer #(
    .DEPTH(D), .SETTLE_CYC(S), .HOLD_CYC(H), .WINDOW(W)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_abort(abort), .cmd_if(cmd_if), .i_rpm_sense(rpm),
    .o_altcmd(alt), .o_dircmd0(d0), .o_dircmd1(d1), .o_busy(busy), .o_chk_valid(cv),
    .o_chk_fail(cf), .o_fail_cnt(fc), .o_seq_idx(si)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [8:0] cmd;
    logic [3:0] fail;
  } sb_t;
  sb_t sb_q[$];

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_fc = '0;
  logic [15:0] exp_si = '0;

  function automatic logic [3:0] model_fail(input logic [63:0] t, input logic [3:0][15:0] s);
    logic [3:0] f;
    logic [15:0] ts;
    int tv, sv;
    for (int i = 0; i < 4; i++) begin
      ts = t[63 - 16*i -: 16];
      tv = int'($signed(ts));
      sv = int'($signed(s[i]));
      f[i] = (sv > tv + W) || (sv < tv - W);
    end
    return f;
  endfunction

  task automatic push_cmd(input logic [8:0] d, input logic [63:0] t, output bit ok);
    ok = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data = d;
    cmd_if.cmd_target = t;
    for (int n = 0; n < 400; n++) begin
      if (cmd_if.cmd_ready) begin
        @(posedge clk);
        ok = 1'b1;
        sb_q.push_back({d, model_fail(t, rpm)});
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_chk(input int bound, output int w);
    w = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (cv) begin
        w = n;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4 * PERIOD; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if ({alt, d0, d1} !== 9'd0) begin errors++; $display("FAIL rst_cmd got %h want 000", {alt, d0, d1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (cv !== 1'b0 || cf !== 4'd0) begin errors++; $display("FAIL rst_chk got %b/%h want 0/0", cv, cf); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_if.cmd_ready); end
    checks++; if (fc !== 16'd0 || si !== 16'd0) begin errors++; $display("FAIL rst_cnt got %h/%h want 0/0", fc, si); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int w; sb_t e;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'd1000};
    push_cmd(9'b001_000_000, {4{16'd1000}}, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_push got timeout want accept"); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || alt !== 3'b000) begin errors++; $display("FAIL t1_fetch got busy=%b alt=%b want 1/000", busy, alt); end
    @(negedge clk);
    checks++; if (alt !== 3'b001) begin errors++; $display("FAIL t1_alt got %b want 001", alt); end
    wait_chk(S + 10, w);
    checks++; if (w !== S + 1) begin errors++; $display("FAIL t1_latency got %0d want %0d", w, S + 1); end
    if (w >= 0) begin
      e = sb_q.pop_front();
      exp_si = exp_si + 16'd1;
      if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
      checks++; if (cf !== e.fail) begin errors++; $display("FAIL t1_chk_fail got %b want %b", cf, e.fail); end
      checks++; if (si !== exp_si || fc !== exp_fc) begin errors++; $display("FAIL t1_cnt got %h/%h want %h/%h", si, fc, exp_si, exp_fc); end
    end
    @(negedge clk);
    checks++; if (cv !== 1'b0) begin errors++; $display("FAIL t1_pulse got %b want 0", cv); end
    repeat (H - 2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_hold_busy got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || {alt, d0, d1} !== 9'd0) begin errors++; $display("FAIL t1_hover got %b/%h want 0/000", busy, {alt, d0, d1}); end
  endtask

  task automatic test_window();
    bit ok; int w; sb_t e;
    rpm[0] = 16'd1006; rpm[1] = 16'd1007; rpm[2] = 16'd994; rpm[3] = 16'd993;
    push_cmd(9'b010_001_011, {4{16'd1000}}, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_push got timeout want accept"); end
    wait_chk(PERIOD + 10, w);
    checks++; if (w < 0) begin errors++; $display("FAIL t2_chk got timeout want chk_valid"); end
    if (w >= 0) begin
      e = sb_q.pop_front();
      exp_si = exp_si + 16'd1;
      if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
      checks++; if (cf !== 4'b1010) begin errors++; $display("FAIL t2_chk_fail got %b want 1010", cf); end
      checks++; if (cf !== e.fail) begin errors++; $display("FAIL t2_model got %b want %b", cf, e.fail); end
      checks++; if (fc !== exp_fc || si !== exp_si) begin errors++; $display("FAIL t2_cnt got %h/%h want %h/%h", fc, si, exp_fc, exp_si); end
      checks++; if ({alt, d0, d1} !== e.cmd) begin errors++; $display("FAIL t2_cmd got %h want %h", {alt, d0, d1}, e.cmd); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_idle got busy want idle"); end
  endtask

  task automatic test_back_to_back();
    bit ok0, oka, okb; int wb, last; sb_t e;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'd1000};
    push_cmd(9'h1C3, {4{16'd1000}}, ok0);
    checks++; if (!ok0) begin errors++; $display("FAIL t3_push0 got timeout want accept"); end
    repeat (3) @(negedge clk);
    last = 0;
    fork
      begin
        for (int k = 0; k < D; k++) begin
          push_cmd(9'((k * 53 + 17) % 512),
                   {16'(1000 + 2 * k), 16'd1000, 16'd1000, 16'(1000 - k)}, oka);
          checks++; if (!oka) begin errors++; $display("FAIL t3_push%0d got timeout want accept", k); end
        end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL t3_full got ready=%b want 0", cmd_if.cmd_ready); end
        push_cmd(9'h0B6, {16'd990, 16'd1000, 16'd1004, 16'd1000}, oka);
        checks++; if (!oka) begin errors++; $display("FAIL t3_push9 got timeout want accept"); end
      end
      begin
        for (int k = 0; k < D + 2; k++) begin
          wait_chk(PERIOD + 10, wb);
          checks++; if (wb < 0) begin errors++; $display("FAIL t3_chk%0d got timeout want chk_valid", k); end
          if (wb >= 0) begin
            if (k > 0) begin
              checks++; if (cyc - last !== PERIOD) begin errors++; $display("FAIL t3_period%0d got %0d want %0d", k, cyc - last, PERIOD); end
            end
            last = cyc;
            e = sb_q.pop_front();
            exp_si = exp_si + 16'd1;
            if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
            checks++; if ({alt, d0, d1} !== e.cmd) begin errors++; $display("FAIL t3_cmd%0d got %h want %h", k, {alt, d0, d1}, e.cmd); end
            checks++; if (cf !== e.fail) begin errors++; $display("FAIL t3_fail%0d got %b want %b", k, cf, e.fail); end
            checks++; if (fc !== exp_fc || si !== exp_si) begin errors++; $display("FAIL t3_cnt%0d got %h/%h want %h/%h", k, fc, si, exp_fc, exp_si); end
          end
        end
      end
    join
    wait_idle(okb);
    checks++; if (!okb) begin errors++; $display("FAIL t3_idle got busy want idle"); end
  endtask

  task automatic test_wrap();
    bit ok; int w; sb_t e;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'h8001};
    push_cmd(9'b011_011_011, {16'h7FFC, 16'd1000, 16'd1000, 16'd1000}, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_push got timeout want accept"); end
    wait_chk(PERIOD + 10, w);
    checks++; if (w < 0) begin errors++; $display("FAIL t4_chk got timeout want chk_valid"); end
    if (w >= 0) begin
      e = sb_q.pop_front();
      exp_si = exp_si + 16'd1;
      if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
      checks++; if (cf !== e.fail) begin errors++; $display("FAIL t4_wrap_fail got %b want %b", cf, e.fail); end
    end
    rpm[0] = 16'h8000;
    push_cmd(9'b100_000_001, {16'h8003, 16'd1000, 16'd1000, 16'd1000}, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_push2 got timeout want accept"); end
    wait_chk(2 * PERIOD, w);
    checks++; if (w < 0) begin errors++; $display("FAIL t4_chk2 got timeout want chk_valid"); end
    if (w >= 0) begin
      e = sb_q.pop_front();
      exp_si = exp_si + 16'd1;
      if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
      checks++; if (cf !== e.fail) begin errors++; $display("FAIL t4_neg_pass got %b want %b", cf, e.fail); end
      checks++; if (fc !== exp_fc || si !== exp_si) begin errors++; $display("FAIL t4_cnt got %h/%h want %h/%h", fc, si, exp_fc, exp_si); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_idle got busy want idle"); end
  endtask

  task automatic test_abort();
    bit ok; int w, nv, nb; sb_t e;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'd1100};
    for (int k = 0; k < 5; k++) begin
      push_cmd(9'(9'h0F1 + 9'(k * 7)), {4{16'd1000}}, ok);
      checks++; if (!ok) begin errors++; $display("FAIL t5_push%0d got timeout want accept", k); end
    end
    for (int k = 0; k < 2; k++) begin
      wait_chk(PERIOD + 10, w);
      checks++; if (w < 0) begin errors++; $display("FAIL t5_chk%0d got timeout want chk_valid", k); end
      if (w >= 0) begin
        e = sb_q.pop_front();
        exp_si = exp_si + 16'd1;
        if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
        checks++; if (fc !== exp_fc || si !== exp_si || cf !== e.fail) begin errors++; $display("FAIL t5_cnt%0d got %h/%h/%b want %h/%h/%b", k, fc, si, cf, exp_fc, exp_si, e.fail); end
      end
    end
    repeat (40) @(negedge clk);
    e = sb_q[0];
    checks++; if ({alt, d0, d1} !== e.cmd || busy !== 1'b1) begin errors++; $display("FAIL t5_settle got %h/%b want %h/1", {alt, d0, d1}, busy, e.cmd); end
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data = 9'h1FF;
    cmd_if.cmd_target = {4{16'd1000}};
    @(negedge clk);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    sb_q.delete();
    exp_fc = '0;
    exp_si = '0;
    checks++; if ({alt, d0, d1} !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL t5_hover got %h/%b want 000/0", {alt, d0, d1}, busy); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL t5_ready got %b want 1", cmd_if.cmd_ready); end
    checks++; if (fc !== 16'd0 || si !== 16'd0 || cf !== 4'd0) begin errors++; $display("FAIL t5_clear got %h/%h/%b want 0/0/0", fc, si, cf); end
    nv = 0; nb = 0;
    for (int n = 0; n < 2 * PERIOD; n++) begin
      @(negedge clk);
      if (cv) nv++;
      if (busy) nb++;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL t5_no_chk got %0d pulses want 0", nv); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL t5_flushed got %0d busy cycles want 0", nb); end
  endtask

  task automatic test_saturate();
    bit ok; int w; sb_t e;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'd1100};
    force dut.r_fail_cnt = 16'hFFFF;
    force dut.r_seq_idx = 16'hFFFF;
    @(negedge clk);
    release dut.r_fail_cnt;
    release dut.r_seq_idx;
    exp_fc = 16'hFFFF;
    exp_si = 16'hFFFF;
    push_cmd(9'b101_110_111, {4{16'd1000}}, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_push got timeout want accept"); end
    wait_chk(PERIOD + 10, w);
    checks++; if (w < 0) begin errors++; $display("FAIL t6_chk got timeout want chk_valid"); end
    if (w >= 0) begin
      e = sb_q.pop_front();
      exp_si = exp_si + 16'd1;
      if (|e.fail && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
      checks++; if (fc !== exp_fc) begin errors++; $display("FAIL t6_sat got %h want %h", fc, exp_fc); end
      checks++; if (si !== exp_si) begin errors++; $display("FAIL t6_wrap got %h want %h", si, exp_si); end
      checks++; if (cf !== e.fail) begin errors++; $display("FAIL t6_fail got %b want %b", cf, e.fail); end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_idle got busy want idle"); end
  endtask

  task automatic test_async_reset();
    bit ok; int nb;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'd1000};
    push_cmd(9'b111_010_101, {4{16'd1000}}, ok);
    push_cmd(9'b110_001_010, {4{16'd1000}}, ok);
    repeat (10) @(negedge clk);
    checks++; if ({alt, d0, d1} !== 9'b111_010_101) begin errors++; $display("FAIL t7_cmd got %b want 111010101", {alt, d0, d1}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({alt, d0, d1} !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL t7_async got %h/%b want 000/0", {alt, d0, d1}, busy); end
    checks++; if (fc !== 16'd0 || si !== 16'd0 || cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL t7_clear got %h/%h/%b want 0/0/1", fc, si, cmd_if.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    exp_fc = '0;
    exp_si = '0;
    nb = 0;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL t7_flushed got %0d busy cycles want 0", nb); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data = '0;
    cmd_if.cmd_target = '0;
    rpm = {16'd1000, 16'd1000, 16'd1000, 16'd1000};
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_window();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
